game_ui_scheduler: RTL and testbench

GAME_UI_SCHEDULER -- requirements
Module: game_ui_scheduler

---
 rtl/game_ui_scheduler_if.sv | 23 ++
 rtl/game_ui_scheduler.sv | 155 +++++++++++++++
 tb/tb_game_ui_scheduler.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/game_ui_scheduler_if.sv
// UI ROM reader handshake: record request/ack, deadline return and game-time feedback.
// master = scheduler side, slave = ROM reader side.
interface game_ui_scheduler_if #(
  parameter int ADDR_WIDTH    = 10,
  parameter int MAXIMUM_TIMES = 30
);
  logic                     update_ui_time;
  logic [MAXIMUM_TIMES-1:0] next_ui_time;
  logic                     is_end;
  logic [MAXIMUM_TIMES-1:0] current_time;
  logic [ADDR_WIDTH-1:0]    addr;
  logic                     sync_ui_time;

  modport master (
    input  update_ui_time, next_ui_time, is_end,
    output current_time, addr, sync_ui_time
  );

  modport slave (
    output update_ui_time, next_ui_time, is_end,
    input  current_time, addr, sync_ui_time
  );
endinterface

// File: rtl/game_ui_scheduler.sv
// Walks UI records in ROM order, applying each one when game time reaches its deadline.
// Optional macro GAME_UI_WATCHDOG_EN: a FETCH lasting 16 cycles without a record aborts to DONE with fetch_err.
module game_ui_scheduler #(
  parameter int ADDR_WIDTH    = 10,
  parameter int MAXIMUM_TIMES = 30,
  parameter int TICK_DIV      = 100000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                pause,
  game_ui_scheduler_if.master ui,
  output logic                ui_apply,
  output logic                running,
  output logic                done,
  output logic                fetch_err
);
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]         DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0]         DIV_ONE  = 1;
  localparam logic [MAXIMUM_TIMES-1:0] TIME_ONE = 1;
  localparam logic [ADDR_WIDTH-1:0]    ADDR_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DONE} state_e;

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [MAXIMUM_TIMES-1:0] time_q, time_d;
  logic [MAXIMUM_TIMES-1:0] deadline_q, deadline_d;
  logic [DIV_W-1:0]         div_q, div_d;
  logic                     start_q;
  logic                     ui_apply_q, ui_apply_d;
  logic                     start_rise;
  logic                     time_run;
  logic [MAXIMUM_TIMES-1:0] time_diff;
  logic                     deadline_hit;

  assign start_rise   = start & ~start_q;
  assign time_run     = (state_q == S_FETCH) || (state_q == S_WAIT);
  // Deadline reached when the modular difference is non-negative; survives counter wrap.
  assign time_diff    = time_q - deadline_q;
  assign deadline_hit = ~time_diff[MAXIMUM_TIMES-1];

`ifdef GAME_UI_WATCHDOG_EN
  logic [3:0] wdog_q, wdog_d;
  logic       fetch_err_q, fetch_err_d;
  logic       wdog_expired;

  assign wdog_expired = (wdog_q == 4'd15);

  always_comb begin
    wdog_d = '0;
    if (state_q == S_FETCH && !ui.update_ui_time) wdog_d = wdog_q + 4'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_q      <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      wdog_q      <= wdog_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign fetch_err = fetch_err_q;
`else
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
    state_d    = state_q;
    addr_d     = addr_q;
    time_d     = time_q;
    div_d      = div_q;
    deadline_d = deadline_q;
    ui_apply_d = 1'b0;
`ifdef GAME_UI_WATCHDOG_EN
    fetch_err_d = fetch_err_q;
`endif

    if (time_run && !pause) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        time_d = time_q + TIME_ONE;
      end else begin
        div_d  = div_q + DIV_ONE;
      end
    end

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_rise) begin
          state_d = S_FETCH;
          addr_d  = '0;
          time_d  = '0;
          div_d   = '0;
        end
      end
      S_FETCH: begin
        if (ui.update_ui_time) begin
          if (ui.is_end) begin
            state_d = S_DONE;
          end else begin
            deadline_d = ui.next_ui_time;
            ui_apply_d = 1'b1;
            state_d    = S_WAIT;
          end
        end
`ifdef GAME_UI_WATCHDOG_EN
        else if (wdog_expired) begin
          fetch_err_d = 1'b1;
          state_d     = S_DONE;
        end
`endif
      end
      S_WAIT: begin
        if (deadline_hit) begin
          addr_d  = addr_q + ADDR_ONE;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!reset_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      time_q     <= '0;
      div_q      <= '0;
      deadline_q <= '0;
      start_q    <= 1'b0;
      ui_apply_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      time_q     <= time_d;
      div_q      <= div_d;
      deadline_q <= deadline_d;
      start_q    <= start;
      ui_apply_q <= ui_apply_d;
    end
  end

  assign ui.sync_ui_time = (state_q != S_FETCH);
  assign ui.addr         = addr_q;
  assign ui.current_time = time_q;
  assign ui_apply        = ui_apply_q;
  assign running         = time_run;
  assign done            = (state_q == S_DONE);
endmodule

// File: tb/tb_game_ui_scheduler.sv
// Directed bench for game_ui_scheduler: TICK_DIV=4, 3-bit record address, 30-bit game time.
// Expected values are hand-derived from edge counts since the start edge.
module tb_game_ui_scheduler;
  localparam int AW = 3;
  localparam int MT = 30;
  localparam int TD = 4;

  logic clk;
  logic reset_n;
  logic start;
  logic pause;
  logic ui_apply;
  logic running;
  logic done;
  logic fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  game_ui_scheduler_if #(.ADDR_WIDTH(AW), .MAXIMUM_TIMES(MT)) ui_if ();

  game_ui_scheduler #(.ADDR_WIDTH(AW), .MAXIMUM_TIMES(MT), .TICK_DIV(TD)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .pause     (pause),
    .ui        (ui_if.master),
    .ui_apply  (ui_apply),
    .running   (running),
    .done      (done),
    .fetch_err (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one record as soon as the scheduler requests it; returns on the negedge after capture.
  task automatic serve(input logic [MT-1:0] deadline, input logic end_flag);
    int n = 0;
    while (ui_if.sync_ui_time !== 1'b0 && n < 50) begin
      step();
      n++;
    end
    check("fetch_request", ui_if.sync_ui_time, 0);
    ui_if.update_ui_time = 1'b1;
    ui_if.next_ui_time   = deadline;
    ui_if.is_end         = end_flag;
    step();
    ui_if.update_ui_time = 1'b0;
    ui_if.is_end         = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    reset_n              = 1'b0;
    start                = 1'b0;
    pause                = 1'b0;
    ui_if.update_ui_time = 1'b0;
    ui_if.next_ui_time   = '0;
    ui_if.is_end         = 1'b0;

    @(negedge clk);
    check("rst_sync",      ui_if.sync_ui_time, 1);
    check("rst_addr",      ui_if.addr, 0);
    check("rst_time",      ui_if.current_time, 0);
    check("rst_ui_apply",  ui_apply, 0);
    check("rst_running",   running, 0);
    check("rst_done",      done, 0);
    check("rst_fetch_err", fetch_err, 0);
    step();
    reset_n = 1'b1;

    // update_ui_time in IDLE must be ignored
    ui_if.update_ui_time = 1'b1;
    repeat (3) step();
    ui_if.update_ui_time = 1'b0;
    check("idle_update_running", running, 0);
    check("idle_update_apply",   ui_apply, 0);
    check("idle_sync",           ui_if.sync_ui_time, 1);

    // Record 0, deadline 3: captured on running edge 1, time reaches 3 on edge 12, advance on edge 13.
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_running", running, 1);
    check("start_sync",    ui_if.sync_ui_time, 0);
    check("start_addr",    ui_if.addr, 0);
    serve(30'd3, 1'b0);
    check("rec0_apply", ui_apply, 1);
    check("rec0_sync",  ui_if.sync_ui_time, 1);
    check("rec0_addr",  ui_if.addr, 0);
    step();
    n = 1;
    check("rec0_apply_once", ui_apply, 0);
    while (ui_if.addr !== 3'd1 && n < 40) begin
      step();
      n++;
    end
    check("rec0_wait_cycles", n, 12);
    check("rec0_time",        ui_if.current_time, 3);
    check("rec0_next_fetch",  ui_if.sync_ui_time, 0);

    // Record 1, deadline 2 already passed: exactly one WAIT cycle.
    serve(30'd2, 1'b0);
    check("rec1_wait_addr", ui_if.addr, 1);
    check("rec1_wait_sync", ui_if.sync_ui_time, 1);
    step();
    check("rec1_adv_addr", ui_if.addr, 2);

    // Record 2 is the terminator: DONE on running edge 16, time = 16/4 = 4.
    serve(30'd0, 1'b1);
    check("end_done",    done, 1);
    check("end_sync",    ui_if.sync_ui_time, 1);
    check("end_running", running, 0);
    check("end_apply",   ui_apply, 0);
    check("end_addr",    ui_if.addr, 2);
    check("end_time",    ui_if.current_time, 4);
    repeat (10) step();
    check("done_hold_time", ui_if.current_time, 4);
    check("done_hold_addr", ui_if.addr, 2);
    check("done_hold_done", done, 1);
    check("done_no_apply",  ui_apply, 0);

    // Restart from DONE.
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_done", done, 0);
    check("restart_addr", ui_if.addr, 0);
    check("restart_time", ui_if.current_time, 0);

    // Deadline 2^30-2 at time 0 lies two units in the past across the wrap: advance after one WAIT cycle.
    serve(30'h3FFF_FFFE, 1'b0);
    check("wrap_dl_apply", ui_apply, 1);
    step();
    check("wrap_dl_addr", ui_if.addr, 1);

    // Records 1..12 with passed deadlines; address wraps 7 -> 0 and ends at 13 mod 8 = 5.
    for (int k = 1; k <= 12; k++) begin
      serve(30'd0, 1'b0);
      step();
      if (k == 7) check("addr_wrap", ui_if.addr, 0);
    end
    check("addr_after_loop", ui_if.addr, 5);

    // Record at addr 5 captured on running edge 27: time 6, divider 3.
    serve(30'd1000, 1'b0);
    check("pre_pause_time", ui_if.current_time, 6);

    // Pause in WAIT for 20 cycles; a stray update/is_end must be ignored.
    pause                = 1'b1;
    ui_if.update_ui_time = 1'b1;
    ui_if.is_end         = 1'b1;
    repeat (20) step();
    check("pause_time",    ui_if.current_time, 6);
    check("pause_addr",    ui_if.addr, 5);
    check("pause_done",    done, 0);
    check("pause_apply",   ui_apply, 0);
    check("pause_running", running, 1);
    ui_if.update_ui_time = 1'b0;
    ui_if.is_end         = 1'b0;
    pause                = 1'b0;
    step();
    check("resume_time1", ui_if.current_time, 7);
    repeat (4) step();
    check("resume_time2", ui_if.current_time, 8);

    // Asynchronous reset mid-WAIT at addr 5, update held high across release.
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_addr",    ui_if.addr, 0);
    check("async_rst_sync",    ui_if.sync_ui_time, 1);
    check("async_rst_time",    ui_if.current_time, 0);
    check("async_rst_running", running, 0);
    ui_if.update_ui_time = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step();
    check("post_rst_apply",   ui_apply, 0);
    check("post_rst_running", running, 0);
    check("post_rst_addr",    ui_if.addr, 0);
    ui_if.update_ui_time = 1'b0;

    // Pause high must not block the FETCH handshake; time stays 0 so deadline 0 advances at once.
    pause = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("pause_fetch_sync", ui_if.sync_ui_time, 0);
    serve(30'd0, 1'b0);
    check("pause_fetch_apply", ui_apply, 1);
    check("pause_fetch_time",  ui_if.current_time, 0);
    step();
    check("pause_fetch_addr",  ui_if.addr, 1);
    pause = 1'b0;

    // Reader never answers the request at addr 1.
`ifdef GAME_UI_WATCHDOG_EN
    repeat (15) step();
    check("wdog_before_done", done, 0);
    step();
    check("wdog_done",      done, 1);
    check("wdog_fetch_err", fetch_err, 1);
    check("wdog_sync",      ui_if.sync_ui_time, 1);
`else
    repeat (30) step();
    check("no_wdog_fetch_err", fetch_err, 0);
    check("no_wdog_done",      done, 0);
    check("no_wdog_sync",      ui_if.sync_ui_time, 0);
    check("no_wdog_running",   running, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
